// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serialiser, LSB first, idle-high line.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module uart_tx_buffered #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            full, empty, push, pop, baud_exp, done;
    logic [7:0]      head;

    assign full     = (count_q == FIFO_FULL);
    assign empty    = (count_q == '0);
    assign push     = tx_valid && !full;
    assign head     = mem_q[rd_ptr_q];
    assign baud_exp = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        pop      = 1'b0;
        done     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = START;
                    baud_d  = '0;
                end
            end
            START: begin
                if (baud_exp) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_exp) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_exp) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_exp) begin
                    done   = 1'b1;
                    baud_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            shift_d  = head;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
        end

        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // tx is registered, so it is driven from the state being entered
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = !full;
    assign tx_busy  = (state_q != IDLE) || !empty;
    assign tx_done  = done;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: line decoded per bit period against a frame/queue model.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

    localparam int C = 4;
    localparam int D = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int BOUND = 20 * FB * C;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx, tx_busy, tx_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_buffered #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    // Frame bit i as it should appear on the line: start, 8 data LSB first, [parity], stop.
    function automatic logic [10:0] expected_frame(input logic [7:0] b);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9] = ^b;
`endif
        return f;
    endfunction

    // Entry: current negedge is the first sample with tx low.
    task automatic capture_frame(output logic [10:0] bits, output int unstable,
                                 output int done_cnt, output int done_pos);
        bits = '1; unstable = 0; done_cnt = 0; done_pos = -1;
        for (int k = 0; k < FB * C; k++) begin
            if (k > 0) @(negedge clk);
            if (k % C == 0) bits[k / C] = tx;
            else if (tx !== bits[k / C]) unstable++;
            if (tx_done === 1'b1) begin
                done_cnt++;
                done_pos = k;
            end
        end
    endtask

    task automatic wait_fall(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_valid = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (tx !== 1'b1)       begin failures++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
        checks++; if (tx_busy !== 1'b0)  begin failures++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
        checks++; if (tx_done !== 1'b0)  begin failures++; $display("FAIL reset_done: got %b expected 0", tx_done); end
    endtask

    task automatic test_single();
        logic [7:0]  singles [3];
        logic [10:0] bits, ef;
        int unstable, dcnt, dpos, idle_bad;
        singles[0] = 8'h55; singles[1] = 8'h07; singles[2] = 8'h03;
        foreach (singles[i]) begin
            ef = expected_frame(singles[i]);
            @(negedge clk); tx_valid = 1'b1; tx_data = singles[i];
            @(negedge clk); tx_valid = 1'b0;
            checks++; if (tx !== 1'b1) begin failures++; $display("FAIL single_latency_early %h: got %b expected 1", singles[i], tx); end
            @(negedge clk);
            checks++; if (tx !== 1'b0) begin failures++; $display("FAIL single_latency_fall %h: got %b expected 0", singles[i], tx); end
            capture_frame(bits, unstable, dcnt, dpos);
            checks++; if (bits[FB-1:0] !== ef[FB-1:0]) begin failures++; $display("FAIL single_bits %h: got %b expected %b", singles[i], bits[FB-1:0], ef[FB-1:0]); end
            checks++; if (unstable !== 0) begin failures++; $display("FAIL single_bit_hold %h: got %0d glitches expected 0", singles[i], unstable); end
            checks++; if (dcnt !== 1) begin failures++; $display("FAIL single_done_count %h: got %0d expected 1", singles[i], dcnt); end
            checks++; if (dpos !== FB * C - 1) begin failures++; $display("FAIL single_done_pos %h: got %0d expected %0d", singles[i], dpos, FB * C - 1); end
            @(negedge clk);
            checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL single_busy_after %h: got %b expected 0", singles[i], tx_busy); end
            idle_bad = 0;
            repeat (2 * C) begin
                if (tx !== 1'b1) idle_bad++;
                @(negedge clk);
            end
            checks++; if (idle_bad !== 0) begin failures++; $display("FAIL single_idle_high %h: got %0d low samples expected 0", singles[i], idle_bad); end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] bits, ef;
        int unstable, dcnt, dpos;
        bit ok;
        @(negedge clk); tx_valid = 1'b1; tx_data = 8'hA5;
        @(negedge clk); tx_data = 8'h3C;
        @(negedge clk); tx_valid = 1'b0;
        wait_fall(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL b2b_start: got no start bit expected one"); end
        capture_frame(bits, unstable, dcnt, dpos);
        ef = expected_frame(8'hA5);
        checks++; if (bits[FB-1:0] !== ef[FB-1:0] || unstable != 0) begin failures++; $display("FAIL b2b_frame1: got %b (%0d glitches) expected %b", bits[FB-1:0], unstable, ef[FB-1:0]); end
        @(negedge clk);
        checks++; if (tx !== 1'b0) begin failures++; $display("FAIL b2b_gap: got %b expected 0 (start of second frame)", tx); end
        capture_frame(bits, unstable, dcnt, dpos);
        ef = expected_frame(8'h3C);
        checks++; if (bits[FB-1:0] !== ef[FB-1:0] || unstable != 0) begin failures++; $display("FAIL b2b_frame2: got %b (%0d glitches) expected %b", bits[FB-1:0], unstable, ef[FB-1:0]); end
        checks++; if (dcnt !== 1) begin failures++; $display("FAIL b2b_done2: got %0d expected 1", dcnt); end
        @(negedge clk);
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_after: got %b expected 0", tx_busy); end
    endtask

    task automatic test_fill();
        logic [7:0]  acc [$];
        logic [10:0] bits, ef;
        int unstable, dcnt, dpos;
        bit took, seen;
        @(negedge clk);
        tx_data = 8'($urandom); tx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            took = (tx_ready === 1'b1);
            if (took) acc.push_back(tx_data);
            @(negedge clk);
            if (took) tx_data = 8'($urandom);
        end
        tx_valid = 1'b0;
        checks++; if (acc.size() !== D + 1) begin failures++; $display("FAIL fill_accepted: got %0d expected %0d", acc.size(), D + 1); end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL fill_ready_low: got %b expected 0", tx_ready); end
        seen = 1'b0;
        for (int i = 0; i < 2 * FB * C; i++) begin
            if (tx_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!seen) begin failures++; $display("FAIL fill_first_done: got none expected a pulse"); end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL fill_ready_at_done: got %b expected 0", tx_ready); end
        @(negedge clk);
        checks++; if (tx_ready !== 1'b1 || tx !== 1'b0) begin failures++; $display("FAIL fill_ready_after_pop: got ready=%b tx=%b expected ready=1 tx=0", tx_ready, tx); end
        for (int j = 1; j < acc.size(); j++) begin
            if (j > 1) begin
                @(negedge clk);
                checks++; if (tx !== 1'b0) begin failures++; $display("FAIL fill_gap %0d: got %b expected 0", j, tx); end
            end
            capture_frame(bits, unstable, dcnt, dpos);
            ef = expected_frame(acc[j]);
            checks++; if (bits[FB-1:0] !== ef[FB-1:0] || unstable != 0) begin failures++; $display("FAIL fill_frame %0d: got %b (%0d glitches) expected %b", j, bits[FB-1:0], unstable, ef[FB-1:0]); end
        end
        @(negedge clk);
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL fill_busy_after: got %b expected 0", tx_busy); end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int bad;
        @(negedge clk); tx_valid = 1'b1; tx_data = 8'hFF;
        @(negedge clk); tx_valid = 1'b0;
        wait_fall(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rstmid_start: got no start bit expected one"); end
        repeat (4 * C + 1) @(negedge clk);
        checks++; if (tx !== 1'b1 || tx_busy !== 1'b1) begin failures++; $display("FAIL rstmid_in_bit3: got tx=%b busy=%b expected 1 1", tx, tx_busy); end
        rst = 1'b1; tx_valid = 1'b1; tx_data = 8'h12;
        @(negedge clk);
        rst = 1'b0; tx_valid = 1'b0;
        checks++; if (tx !== 1'b1)       begin failures++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
        checks++; if (tx_busy !== 1'b0)  begin failures++; $display("FAIL rstmid_busy: got %b expected 0", tx_busy); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready: got %b expected 1", tx_ready); end
        bad = 0;
        repeat (3 * FB * C) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL rstmid_no_resume: got %0d active samples expected 0", bad); end
    endtask

    task automatic test_random();
        localparam int N = 10;
        logic [7:0] bytes [N];
        int         gaps  [N];
        logic [7:0] exp_q [$];
        for (int i = 0; i < N; i++) begin
            bytes[i] = 8'($urandom);
            gaps[i]  = (i % 3 == 0) ? $urandom_range(0, 2 * FB * C) : $urandom_range(0, 2);
        end
        @(negedge clk);
        fork
            begin
                bit took;
                for (int i = 0; i < N; i++) begin
                    repeat (gaps[i]) @(negedge clk);
                    tx_data = bytes[i]; tx_valid = 1'b1;
                    took = 1'b0;
                    for (int t = 0; t < BOUND && !took; t++) begin
                        took = (tx_ready === 1'b1);
                        if (took) exp_q.push_back(bytes[i]);
                        @(negedge clk);
                    end
                    tx_valid = 1'b0;
                    checks++; if (!took) begin failures++; $display("FAIL rand_accept %0d: got no handshake expected accept", i); end
                end
            end
            begin
                logic [10:0] bits, ef;
                logic [7:0]  want;
                int unstable, dcnt, dpos;
                bit ok;
                for (int i = 0; i < N; i++) begin
                    wait_fall(ok);
                    checks++; if (!ok) begin failures++; $display("FAIL rand_start %0d: got no start bit expected one", i); break; end
                    want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    capture_frame(bits, unstable, dcnt, dpos);
                    ef = expected_frame(want);
                    checks++; if (bits[FB-1:0] !== ef[FB-1:0] || unstable != 0) begin failures++; $display("FAIL rand_frame %0d: got %b (%0d glitches) expected %b", i, bits[FB-1:0], unstable, ef[FB-1:0]); end
                    checks++; if (dcnt !== 1 || dpos !== FB * C - 1) begin failures++; $display("FAIL rand_done %0d: got count=%0d pos=%0d expected 1 at %0d", i, dcnt, dpos, FB * C - 1); end
                    @(negedge clk);
                end
            end
        join
        repeat (2) @(negedge clk);
        checks++; if (tx_busy !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL rand_drained: got busy=%b pending=%0d expected 0 0", tx_busy, exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
